// File: rtl/tpu_sequencer_if.sv
// Host/array-side bus of the TPU instruction sequencer.
// master: host + unified buffer side (drives start, program writes, store_ack).
// slave : sequencer side (drives array strobes, base address and status).
//   start        begin program at pc 0
//   imem_we      instruction memory write strobe (ignored while busy)
//   imem_waddr   instruction memory write address
//   imem_wdata   instruction memory write data
//   store_ack    unified buffer accepted the store
//   load_weight  weight load strobe
//   load_input   input load strobe
//   valid        array compute enable
//   store        store request
//   base_address buffer base address
//   pc           current program counter
//   busy/done    status (FETCH or EXECUTE / DONE)
//   error        sticky program-overrun flag
interface tpu_sequencer_if #(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned IMEM_DEPTH = 16
);
  localparam int unsigned PC_W   = $clog2(IMEM_DEPTH);
  localparam int unsigned OPND_W = INSTR_W - 3;

  logic              start;
  logic              imem_we;
  logic [PC_W-1:0]   imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic              store_ack;
  logic              load_weight;
  logic              load_input;
  logic              valid;
  logic              store;
  logic [OPND_W-1:0] base_address;
  logic [PC_W-1:0]   pc;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, imem_we, imem_waddr, imem_wdata, store_ack,
    input  load_weight, load_input, valid, store, base_address, pc, busy, done, error
  );

  modport slave (
    input  start, imem_we, imem_waddr, imem_wdata, store_ack,
    output load_weight, load_input, valid, store, base_address, pc, busy, done, error
  );
endinterface

// File: rtl/tpu_sequencer.sv
// Programmable instruction sequencer for the systolic-array TPU.
// Runs a FETCH/EXECUTE loop over a host-loadable instruction memory and drives the
// weight-load, input-load, compute-valid, store and base-address controls.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high; clears all outputs, state, pc and loop state
//   bus    tpu_sequencer_if.slave (program load, store handshake, array controls, status)
// Instruction: opcode in the top 3 bits, operand in the low INSTR_W-3 bits.
module tpu_sequencer #(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned ARRAY_N    = 2
) (
  input logic            clk,
  input logic            reset,
  tpu_sequencer_if.slave bus
);
  localparam int unsigned PC_W   = $clog2(IMEM_DEPTH);
  localparam int unsigned OPND_W = INSTR_W - 3;

  localparam logic [2:0] OpHalt     = 3'd0;
  localparam logic [2:0] OpLoadAddr = 3'd1;
  localparam logic [2:0] OpLoadWgt  = 3'd2;
  localparam logic [2:0] OpLoadInp  = 3'd3;
  localparam logic [2:0] OpCompute  = 3'd4;
  localparam logic [2:0] OpStore    = 3'd5;
  localparam logic [2:0] OpLoop     = 3'd6;

  typedef enum logic [1:0] {StIdle, StFetch, StExecute, StDone} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [OPND_W-1:0]   cnt_q, cnt_d;
  logic                loop_active_q, loop_active_d;
  logic [3:0]          loop_cnt_q, loop_cnt_d;
  logic                load_weight_q, load_weight_d;
  logic                load_input_q, load_input_d;
  logic                valid_q, valid_d;
  logic                store_q, store_d;
  logic [OPND_W-1:0]   base_q, base_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [INSTR_W-1:0]  imem [IMEM_DEPTH];
  logic                imem_wen;
  logic [INSTR_W-1:0]  fetch_word;
  logic [2:0]          fetch_op;
  logic [2:0]          ir_op;
  logic [OPND_W-1:0]   ir_opnd;
  logic [OPND_W-1:0]   compute_len;
  logic [PC_W-1:0]     loop_tgt;
  logic [3:0]          loop_n;
  logic                advance;
  logic                jump;

  assign imem_wen    = bus.imem_we && (state_q == StIdle || state_q == StDone);
  assign fetch_word  = imem[pc_q];
  assign fetch_op    = fetch_word[INSTR_W-1 -: 3];
  assign ir_op       = ir_q[INSTR_W-1 -: 3];
  assign ir_opnd     = ir_q[OPND_W-1:0];
  assign compute_len = (ir_opnd == '0) ? OPND_W'(2 * ARRAY_N) : ir_opnd;
  assign loop_tgt    = ir_opnd[PC_W-1:0];
  assign loop_n      = ir_opnd[PC_W+3:PC_W];

  // Program memory has no reset; contents survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (imem_wen) begin
      imem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    cnt_d         = cnt_q;
    loop_active_d = loop_active_q;
    loop_cnt_d    = loop_cnt_q;
    load_weight_d = 1'b0;
    load_input_d  = 1'b0;
    valid_d       = 1'b0;
    store_d       = 1'b0;
    base_d        = base_q;
    error_d       = error_q;
    advance       = 1'b0;
    jump          = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d       = StFetch;
          pc_d          = '0;
          error_d       = 1'b0;
          loop_active_d = 1'b0;
          loop_cnt_d    = '0;
        end
      end
      StFetch: begin
        // Strobes are decoded from the word being fetched so they appear in the
        // first EXECUTE cycle.
        state_d = StExecute;
        ir_d    = fetch_word;
        cnt_d   = '0;
        case (fetch_op)
          OpLoadAddr: base_d        = fetch_word[OPND_W-1:0];
          OpLoadWgt:  load_weight_d = 1'b1;
          OpLoadInp:  load_input_d  = 1'b1;
          OpCompute:  valid_d       = 1'b1;
          OpStore:    store_d       = 1'b1;
          default:    ;
        endcase
      end
      StExecute: begin
        case (ir_op)
          OpHalt: state_d = StDone;
          OpCompute: begin
            // cnt_q counts completed valid cycles before this one.
            if ((cnt_q + OPND_W'(1)) < compute_len) begin
              cnt_d   = cnt_q + OPND_W'(1);
              valid_d = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end
          OpStore: begin
            if (bus.store_ack) advance = 1'b1;
            else               store_d = 1'b1;
          end
          OpLoop: begin
            if (!loop_active_q) begin
              if (loop_n == 4'd0) begin
                advance = 1'b1;
              end else begin
                loop_active_d = 1'b1;
                loop_cnt_d    = loop_n - 4'd1;
                jump          = 1'b1;
              end
            end else if (loop_cnt_q != 4'd0) begin
              loop_cnt_d = loop_cnt_q - 4'd1;
              jump       = 1'b1;
            end else begin
              loop_active_d = 1'b0;
              advance       = 1'b1;
            end
          end
          default: advance = 1'b1;
        endcase

        if (jump) begin
          pc_d    = loop_tgt;
          state_d = StFetch;
        end else if (advance) begin
          // Falling off the end of memory is an overrun; never wrap.
          if (pc_q == PC_W'(IMEM_DEPTH - 1)) begin
            state_d = StDone;
            error_d = 1'b1;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = StFetch;
          end
        end
      end
    endcase

    busy_d = (state_d == StFetch) || (state_d == StExecute);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      ir_q          <= '0;
      cnt_q         <= '0;
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
      load_weight_q <= 1'b0;
      load_input_q  <= 1'b0;
      valid_q       <= 1'b0;
      store_q       <= 1'b0;
      base_q        <= '0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      cnt_q         <= cnt_d;
      loop_active_q <= loop_active_d;
      loop_cnt_q    <= loop_cnt_d;
      load_weight_q <= load_weight_d;
      load_input_q  <= load_input_d;
      valid_q       <= valid_d;
      store_q       <= store_d;
      base_q        <= base_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.load_weight  = load_weight_q;
  assign bus.load_input   = load_input_q;
  assign bus.valid        = valid_q;
  assign bus.store        = store_q;
  assign bus.base_address = base_q;
  assign bus.pc           = pc_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer: table of directed programs with expected
// strobe counts, hand-written multi-cycle sequences, and random programs checked
// cycle by cycle against an instruction-level reference model.
module tb_tpu_sequencer;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned IMEM_DEPTH = 16;
  localparam int unsigned ARRAY_N    = 2;
  localparam int unsigned PC_W       = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tpu_sequencer_if #(.INSTR_W(INSTR_W), .IMEM_DEPTH(IMEM_DEPTH)) bus ();

  tpu_sequencer #(.INSTR_W(INSTR_W), .IMEM_DEPTH(IMEM_DEPTH), .ARRAY_N(ARRAY_N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [12:0] base_m;

  typedef struct packed {
    logic [15:0][15:0] prog;
    logic              reload;
    logic              disturb;
    int unsigned       n_lw;
    int unsigned       n_li;
    int unsigned       n_valid;
    int unsigned       valid_run;
    int unsigned       n_store;
    int unsigned       n_busy;
    logic [3:0]        end_pc;
    logic [12:0]       end_base;
    logic              end_err;
  } vec_t;

  typedef struct packed {
    logic lw, li, v, st, ack, busy, done, err;
    logic [3:0]  pc;
    logic [12:0] base;
  } exp_t;

  vec_t vecs[8];
  exp_t tr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  function automatic logic [15:0] ins(input logic [2:0] op, input logic [12:0] opnd);
    return {op, opnd};
  endfunction

  function automatic logic [31:0] obs();
    return {8'd0, bus.load_weight, bus.load_input, bus.valid, bus.store, bus.busy,
            bus.done, bus.error, bus.pc, bus.base_address};
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic exp_t mk(input bit lw, input bit li, input bit v, input bit st,
                              input bit ack, input int pc);
    exp_t e;
    e.lw = lw; e.li = li; e.v = v; e.st = st; e.ack = ack;
    e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0;
    e.pc = 4'(pc); e.base = base_m;
    return e;
  endfunction

  task automatic load_prog(input logic [15:0][15:0] p);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.imem_we = 1'b1; bus.imem_waddr = PC_W'(i); bus.imem_wdata = p[i];
    end
    @(negedge clk);
    bus.imem_we = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first FETCH cycle.
  task automatic do_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic run_entry(input vec_t v, input string tag);
    int lw = 0, li = 0, nv = 0, run = 0, maxrun = 0, st = 0, nb = 0;
    bit fin = 0;
    if (v.reload) load_prog(v.prog);
    bus.store_ack = 1'b1;
    do_start();
    check($sformatf("%s start_clr", tag), {bus.error, bus.done}, 0);
    for (int c = 0; c < 1000; c++) begin
      if (c > 0) @(negedge clk);
      if (!bus.busy) begin fin = 1; break; end
      nb++;
      lw += int'(bus.load_weight);
      li += int'(bus.load_input);
      st += int'(bus.store);
      if (bus.valid) begin
        nv++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      // Writes and start while busy must have no effect.
      if (v.disturb && c == 3) begin
        bus.imem_we = 1'b1; bus.imem_waddr = 4'd1; bus.imem_wdata = 16'h0000;
        bus.start = 1'b1;
      end else begin
        bus.imem_we = 1'b0; bus.start = 1'b0;
      end
    end
    bus.imem_we = 1'b0; bus.start = 1'b0;
    check($sformatf("%s timeout", tag), 32'(fin), 1);
    check($sformatf("%s lw", tag), lw, v.n_lw);
    check($sformatf("%s li", tag), li, v.n_li);
    check($sformatf("%s valid", tag), nv, v.n_valid);
    check($sformatf("%s valid_run", tag), maxrun, v.valid_run);
    check($sformatf("%s store", tag), st, v.n_store);
    check($sformatf("%s busy_cycles", tag), nb, v.n_busy);
    check($sformatf("%s done", tag), bus.done, 1);
    check($sformatf("%s error", tag), bus.error, v.end_err);
    check($sformatf("%s pc", tag), bus.pc, v.end_pc);
    check($sformatf("%s base", tag), bus.base_address, v.end_base);
  endtask

  // Instruction-level interpreter producing the expected per-cycle outputs.
  task automatic build_trace(input logic [15:0][15:0] p);
    int pc, op, opnd, tgt, n, lc, c, d;
    bit act, fin, err, jump;
    exp_t e;
    pc = 0; act = 0; lc = 0; fin = 0; err = 0; tgt = 0;
    tr.delete();
    while (!fin) begin
      op = int'(p[pc][15:13]);
      opnd = int'(p[pc][12:0]);
      jump = 0;
      tr.push_back(mk(0, 0, 0, 0, rnd(), pc));
      case (op)
        0: begin tr.push_back(mk(0, 0, 0, 0, rnd(), pc)); fin = 1; end
        1: begin base_m = 13'(opnd); tr.push_back(mk(0, 0, 0, 0, rnd(), pc)); end
        2: tr.push_back(mk(1, 0, 0, 0, rnd(), pc));
        3: tr.push_back(mk(0, 1, 0, 0, rnd(), pc));
        4: begin
          c = (opnd == 0) ? int'(2 * ARRAY_N) : opnd;
          repeat (c) tr.push_back(mk(0, 0, 1, 0, rnd(), pc));
        end
        5: begin
          d = int'($urandom_range(0, 3));
          repeat (d) tr.push_back(mk(0, 0, 0, 1, 0, pc));
          tr.push_back(mk(0, 0, 0, 1, 1, pc));
        end
        6: begin
          tr.push_back(mk(0, 0, 0, 0, rnd(), pc));
          tgt = opnd % 16;
          n = (opnd / 16) % 16;
          if (!act) begin
            if (n > 0) begin act = 1; lc = n - 1; jump = 1; end
          end else if (lc > 0) begin
            lc--; jump = 1;
          end else act = 0;
        end
        default: tr.push_back(mk(0, 0, 0, 0, rnd(), pc));
      endcase
      if (!fin) begin
        if (jump) pc = tgt;
        else if (pc == 15) begin err = 1; fin = 1; end
        else pc++;
      end
    end
    e = mk(0, 0, 0, 0, 0, pc);
    e.busy = 1'b0; e.done = 1'b1; e.err = err;
    tr.push_back(e);
  endtask

  task automatic gen_prog(output logic [15:0][15:0] p);
    int len, k;
    bit has_loop;
    len = int'($urandom_range(1, 16));
    has_loop = 0;
    for (int i = 0; i < 16; i++) begin
      if (i >= len) p[i] = 16'h0000;
      else begin
        k = int'($urandom_range(0, 6));
        case (k)
          0: p[i] = ins(3'd1, 13'($urandom()));
          1: p[i] = ins(3'd2, 13'($urandom()));
          2: p[i] = ins(3'd3, 13'($urandom()));
          3: p[i] = ins(3'd4, 13'($urandom_range(0, 5)));
          4: p[i] = ins(3'd5, 13'($urandom()));
          5: begin
            if (!has_loop) begin
              has_loop = 1;
              p[i] = ins(3'd6, 13'($urandom_range(0, 3) * 16 + $urandom_range(0, i)));
            end else p[i] = ins(3'd7, 13'($urandom()));
          end
          default: p[i] = ins(3'd7, 13'($urandom()));
        endcase
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][15:0] p;
    exp_t e;

    reset = 1'b1;
    bus.start = 1'b0; bus.imem_we = 1'b0; bus.imem_waddr = '0;
    bus.imem_wdata = '0; bus.store_ack = 1'b0;

    // ---- Directed program table ----
    for (int i = 0; i < 8; i++) vecs[i] = '0;
    vecs[0].prog[0] = ins(3'd1, 13'h010);
    vecs[0].prog[1] = ins(3'd2, 13'h000);
    vecs[0].prog[2] = ins(3'd3, 13'h000);
    vecs[0].prog[3] = ins(3'd4, 13'h000);
    vecs[0].prog[4] = ins(3'd5, 13'h000);
    vecs[0].reload = 1; vecs[0].disturb = 1;
    vecs[0].n_lw = 1; vecs[0].n_li = 1; vecs[0].n_valid = 4; vecs[0].valid_run = 4;
    vecs[0].n_store = 1; vecs[0].n_busy = 15; vecs[0].end_pc = 4'd5;
    vecs[0].end_base = 13'h010;
    vecs[1] = vecs[0]; vecs[1].reload = 0; vecs[1].disturb = 0;

    vecs[2].prog[0] = ins(3'd4, 13'd7);
    vecs[2].prog[1] = ins(3'd1, 13'h1AB);
    vecs[2].reload = 1; vecs[2].n_valid = 7; vecs[2].valid_run = 7; vecs[2].n_busy = 12;
    vecs[2].end_pc = 4'd2; vecs[2].end_base = 13'h1AB;

    vecs[3].prog[0] = ins(3'd1, 13'h005);
    vecs[3].prog[1] = ins(3'd3, 13'h000);
    vecs[3].prog[2] = ins(3'd4, 13'd2);
    vecs[3].prog[3] = ins(3'd6, 13'h021);
    vecs[3].reload = 1; vecs[3].n_li = 3; vecs[3].n_valid = 6; vecs[3].valid_run = 2;
    vecs[3].n_busy = 25; vecs[3].end_pc = 4'd4; vecs[3].end_base = 13'h005;

    for (int i = 0; i < 16; i++) vecs[4].prog[i] = ins(3'd2, 13'h000);
    vecs[4].reload = 1; vecs[4].disturb = 1; vecs[4].n_lw = 16; vecs[4].n_busy = 32;
    vecs[4].end_pc = 4'd15; vecs[4].end_base = 13'h005; vecs[4].end_err = 1;
    vecs[5] = vecs[4]; vecs[5].reload = 0; vecs[5].disturb = 0;

    vecs[6].prog[0] = ins(3'd7, 13'h1FFF);
    vecs[6].prog[1] = ins(3'd6, 13'h000);
    vecs[6].reload = 1; vecs[6].n_busy = 6; vecs[6].end_pc = 4'd2;
    vecs[6].end_base = 13'h005;

    // Loop at the last address: its jump is not an overrun, its fall-through is.
    vecs[7].prog[0] = ins(3'd4, 13'd1);
    for (int i = 1; i < 14; i++) vecs[7].prog[i] = ins(3'd7, 13'h000);
    vecs[7].prog[14] = ins(3'd3, 13'h000);
    vecs[7].prog[15] = ins(3'd6, 13'h01E);
    vecs[7].reload = 1; vecs[7].n_li = 2; vecs[7].n_valid = 1; vecs[7].valid_run = 1;
    vecs[7].n_busy = 36; vecs[7].end_pc = 4'd15; vecs[7].end_base = 13'h005;
    vecs[7].end_err = 1;

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    check("reset outputs", obs(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle after reset", obs(), 0);

    for (int i = 0; i < 8; i++) run_entry(vecs[i], $sformatf("vec%0d", i));

    // ---- Delayed store_ack; early ack during COMPUTE is ignored ----
    p = '0;
    p[0] = ins(3'd4, 13'd2);
    p[1] = ins(3'd5, 13'd0);
    load_prog(p);
    bus.store_ack = 1'b0;
    do_start();
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("ack_delay store c%0d", c), bus.store, 32'(c >= 4 && c <= 7));
      check($sformatf("ack_delay valid c%0d", c), bus.valid, 32'(c == 1 || c == 2));
      if (c == 8) check("ack_delay next fetch pc", {bus.busy, bus.pc}, {1'b1, 4'd2});
      if (c == 10) check("ack_delay done", {bus.done, bus.busy}, 2'b10);
      bus.store_ack = (c == 1 || c == 7);
    end
    bus.store_ack = 1'b0;

    // ---- Reset during the third valid cycle, then rerun unchanged program ----
    load_prog(vecs[0].prog);
    bus.store_ack = 1'b1;
    do_start();
    repeat (9) @(negedge clk);
    check("mid_reset valid before", bus.valid, 1);
    #1 reset = 1'b1;
    #1 check("mid_reset outputs", obs(), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset idle", obs(), 0);
    run_entry(vecs[1], "rerun_after_reset");

    // ---- Random programs against the reference model ----
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    base_m = '0;
    for (int r = 0; r < 25; r++) begin
      gen_prog(p);
      load_prog(p);
      build_trace(p);
      do_start();
      for (int k = 0; k < tr.size(); k++) begin
        if (k > 0) @(negedge clk);
        e = tr[k];
        check($sformatf("rand%0d cyc%0d", r, k), obs(),
              {8'd0, e.lw, e.li, e.v, e.st, e.busy, e.done, e.err, e.pc, e.base});
        bus.store_ack = e.ack;
      end
      bus.store_ack = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
- Parametrised, programmable instruction sequencer for the systolic-array TPU.
- Holds a loadable instruction memory and runs a fetch/execute loop.
- Drives the weight-load, input-load, compute-valid, store and base-address controls of the array and unified buffer.
- Adds over the first-generation controller: host program loading, variable-length COMPUTE, a single-level hardware LOOP, a STORE acknowledge stall, and busy/done/error status.

Parameters:
- INSTR_W, 16: instruction width. Opcode is bits [INSTR_W-1:INSTR_W-3]; operand is the low OPND_W = INSTR_W-3 bits.
- IMEM_DEPTH, 16: instruction memory entries (power of 2). PC_W = clog2(IMEM_DEPTH).
- ARRAY_N, 2: systolic array dimension. Default compute length is 2*ARRAY_N cycles.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin program at pc 0; honoured only in IDLE or DONE
- imem_we  in  1  instruction memory write strobe; honoured only in IDLE or DONE
- imem_waddr  in  PC_W  write address
- imem_wdata  in  INSTR_W  write data
- store_ack  in  1  unified buffer accepted the store
- load_weight  out  1  weight load strobe
- load_input  out  1  input load strobe
- valid  out  1  array compute enable
- store  out  1  store request
- base_address  out  OPND_W  buffer base address
- pc  out  PC_W  current program counter
- busy  out  1  high in FETCH and EXECUTE
- done  out  1  high in DONE
- error  out  1  sticky program-overrun flag; cleared by start or reset

Behaviour:
- Opcodes:
  - 000 HALT
  - 001 LOAD_ADDR: base_address <= operand
  - 010 LOAD_WEIGHT
  - 011 LOAD_INPUTS
  - 100 COMPUTE: C = operand; C=0 means 2*ARRAY_N
  - 101 STORE
  - 110 LOOP: target = operand[PC_W-1:0], count N = operand[PC_W+3:PC_W]
  - 111 reserved, executes as a 1-cycle NOP
- States: IDLE, FETCH, EXECUTE, DONE.
  - IDLE --start--> FETCH
  - FETCH: instruction register <= imem[pc] (1 cycle), then EXECUTE
  - EXECUTE --complete--> FETCH with next pc
  - HALT in EXECUTE --> DONE
  - DONE --start--> FETCH with pc=0, done and error cleared
- All outputs are registered. Strobes and base_address change on the FETCH->EXECUTE edge. Strobes are high only in EXECUTE cycles of their opcode and are 0 in every other cycle.
- Timing: start sampled at edge t puts FETCH at t+1 and the first EXECUTE at t+2. Single-cycle instructions occupy 2 cycles (FETCH + EXECUTE).
- COMPUTE: valid is high for exactly C consecutive EXECUTE cycles, then pc+1.
- STORE: store stays high in EXECUTE until store_ack is sampled high, including on the first EXECUTE cycle; store deasserts the next cycle and pc advances. store_ack outside STORE is ignored.
- LOOP (single level; a loop_active flag and a 4-bit counter):
  - inactive, N=0: fall through
  - inactive, N>0: set active, counter <= N-1, pc <= target
  - active, counter>0: counter-1, pc <= target
  - active, counter=0: clear active, fall through
  - Net effect: the body runs N+1 times. A nested LOOP corrupts the outer loop; this is documented, not detected.
- Overrun: if a non-HALT, non-jumping instruction executes at pc = IMEM_DEPTH-1, go to DONE with error=1. No wrap.
- base_address holds its value across instructions and program runs; only reset clears it.
- start while busy is ignored. imem_we while busy is ignored; no write occurs.
- Reset (any state, including mid-COMPUTE or mid-STORE): all outputs 0 immediately, state IDLE, pc 0, loop cleared. imem contents are not reset.
- busy=0 and done=0 in IDLE.

Test Plan:
- Load [LOAD_ADDR 0x010, LOAD_WEIGHT, LOAD_INPUTS, COMPUTE 0, STORE, HALT], ARRAY_N=2, store_ack tied 1, pulse start -> base_address=0x010 at cycle t+2; load_weight 1 cycle; load_input 1 cycle; valid exactly 4 cycles; store 1 cycle; done=1 and busy=0 after HALT; error=0.
- COMPUTE 7 -> valid high exactly 7 consecutive cycles; pc steps by 1 afterwards.
- STORE with store_ack delayed 3 cycles -> store high 4 cycles (ack sampled on the 4th), then the next FETCH; an early store_ack pulse during COMPUTE has no effect.
- Body LOAD_INPUTS, COMPUTE 2 at pc 1-2, LOOP target=1 N=2 at pc 3, HALT -> load_input pulses 3 times, valid totals 6 cycles, then done.
- imem of 16 entries with no HALT -> done=1, error=1 after pc 15. Restart with start -> error cleared. imem_we pulses while busy leave memory unchanged (read back via rerun).
- Assert reset during the 3rd valid cycle -> valid=0 in the same cycle, state IDLE, pc 0. Re-issuing start reruns the original program unchanged.
